// File: rtl/sand_pkg.sv
// Shared cell encoding and LFSR constants for the streaming sand row update.
package sand_pkg;

  typedef enum logic [1:0] {
    AIR     = 2'b00,
    SAND    = 2'b01,
    SAND_AM = 2'b10,
    WALL    = 2'b11
  } cell_t;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8; // x^8 + x^6 + x^5 + x^4 + 1

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sand_word_step.sv
// One gravity step over a single CELLS-wide word, scanning left to right and
// reading/writing the floor as it goes so later cells see earlier moves.
module sand_word_step
  import sand_pkg::*;
#(
  parameter int CELLS = 16
) (
  input  logic [2*CELLS-1:0] region,
  input  logic [2*CELLS-1:0] floor,
  input  logic [1:0]         left_nb,
  input  logic [1:0]         right_nb,
  input  logic               dir_in,
  output logic [2*CELLS-1:0] new_region,
  output logic [2*CELLS-1:0] new_floor,
  output logic               left_patch,
  output logic               right_patch,
  output logic               dir_out
);

  // ext[CELLS+1] is the left neighbour, ext[0] the right neighbour.
  cell_t ext [CELLS+2];
  cell_t cur;
  logic  d;
  logic  tie;
  logic  go_left;

  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    new_region  = region;
    new_floor   = '0;
    left_patch  = 1'b0;
    right_patch = 1'b0;
    d           = dir_in;
    cur         = AIR;
    tie         = 1'b0;
    go_left     = 1'b0;
    ext[0]       = cell_t'(right_nb);
    ext[CELLS+1] = cell_t'(left_nb);
    for (int i = 0; i < CELLS; i++) ext[i+1] = cell_t'(floor[2*i +: 2]);

    for (int i = CELLS - 1; i >= 0; i--) begin
      cur = cell_t'(region[2*i +: 2]);
      if (cur == SAND_AM) begin
        new_region[2*i +: 2] = SAND;
      end else if (cur == SAND) begin
        if (ext[i+1] == AIR) begin
          new_region[2*i +: 2] = AIR;
          ext[i+1] = SAND_AM;
        end else if (ext[i+2] == AIR || ext[i] == AIR) begin
          tie     = (ext[i+2] == AIR) && (ext[i] == AIR);
          go_left = tie ? !d : (ext[i+2] == AIR);
          if (tie) d = !d;
          new_region[2*i +: 2] = AIR;
          if (go_left) begin
            ext[i+2] = SAND_AM;
            if (i == CELLS - 1) left_patch = 1'b1;
          end else begin
            ext[i] = SAND_AM;
            if (i == 0) right_patch = 1'b1;
          end
        end
      end
    end

    for (int i = 0; i < CELLS; i++) new_floor[2*i +: 2] = ext[i+1];
    dir_out = d;
  end

endmodule

// File: rtl/sand_row_stream.sv
// Streaming row-pair gravity step with a C/P/O three-slot window.
// Define SAND_LFSR_EN to randomise the starting tie direction of each word.
module sand_row_stream
  import sand_pkg::*;
#(
  parameter int CELLS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*CELLS-1:0] in_region,
  input  logic [2*CELLS-1:0] in_floor,
  input  logic               in_first,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*CELLS-1:0] out_region,
  output logic [2*CELLS-1:0] out_floor,
  output logic               out_first,
  output logic               out_last
);

  localparam int W = 2 * CELLS;

  logic         c_valid, c_first, c_last;
  logic [W-1:0] c_region, c_floor;
  logic         p_valid, p_first, p_last;
  logic [W-1:0] p_region, p_floor;
  logic         dir;

  logic         o_free, accept, proc, p_to_o;
  logic [1:0]   left_nb, right_nb;
  logic [W-1:0] s_region, s_floor;
  logic         left_patch, right_patch;
  logic         dir_in, dir_out, dir_next;
  logic [W-1:0] p_floor_patched, n_floor;

  assign o_free   = !out_valid || out_ready;
  assign in_ready = !c_valid || (!c_last && o_free);
  assign accept   = in_valid && in_ready;
  // C is processed once its right neighbour is known: the next word or the row edge.
  assign proc     = c_valid && o_free && (c_last || in_valid);
  assign p_to_o   = p_valid && o_free && (proc || p_last);

  assign left_nb  = c_first ? WALL : p_floor[1:0];
  assign right_nb = c_last  ? WALL : in_floor[W-1 -: 2];

`ifdef SAND_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     lfsr <= LFSR_SEED;
    else if (proc) lfsr <= lfsr_next(lfsr);
  end

  assign dir_in   = dir ^ lfsr[0];
  assign dir_next = dir_out ^ lfsr[0];
`else
  assign dir_in   = dir;
  assign dir_next = dir_out;
`endif

  sand_word_step #(.CELLS(CELLS)) u_step (
    .region      (c_region),
    .floor       (c_floor),
    .left_nb     (left_nb),
    .right_nb    (right_nb),
    .dir_in      (dir_in),
    .new_region  (s_region),
    .new_floor   (s_floor),
    .left_patch  (left_patch),
    .right_patch (right_patch),
    .dir_out     (dir_out)
  );

  assign p_floor_patched = {p_floor[W-1:2], (proc && left_patch) ? SAND_AM : p_floor[1:0]};
  assign n_floor         = {(proc && right_patch) ? SAND_AM : in_floor[W-1 -: 2], in_floor[W-3:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_valid    <= 1'b0;
      c_first    <= 1'b0;
      c_last     <= 1'b0;
      c_region   <= '0;
      c_floor    <= '0;
      p_valid    <= 1'b0;
      p_first    <= 1'b0;
      p_last     <= 1'b0;
      p_region   <= '0;
      p_floor    <= '0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_region <= '0;
      out_floor  <= '0;
      dir        <= 1'b0;
    end else begin
      if (accept) begin
        c_valid  <= 1'b1;
        c_first  <= in_first;
        c_last   <= in_last;
        c_region <= in_region;
        c_floor  <= n_floor;
      end else if (proc) begin
        c_valid <= 1'b0;
      end

      if (proc) begin
        p_valid  <= 1'b1;
        p_first  <= c_first;
        p_last   <= c_last;
        p_region <= s_region;
        p_floor  <= s_floor;
        dir      <= dir_next;
      end else if (p_to_o) begin
        p_valid <= 1'b0;
      end

      if (p_to_o) begin
        out_valid  <= 1'b1;
        out_first  <= p_first;
        out_last   <= p_last;
        out_region <= p_region;
        out_floor  <= p_floor_patched;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sand_row_stream.sv
// Self-checking bench for sand_row_stream (CELLS=4): directed cases plus random
// rows compared against a whole-row cell-by-cell reference model.
module tb_sand_row_stream;
  import sand_pkg::*;

  localparam int CELLS = 4;
  localparam int W     = 2 * CELLS;

  logic         clk, reset;
  logic         in_valid, in_ready, in_first, in_last;
  logic [W-1:0] in_region, in_floor;
  logic         out_valid, out_ready, out_first, out_last;
  logic [W-1:0] out_region, out_floor;

  typedef struct packed {
    logic [W-1:0] region;
    logic [W-1:0] floor;
    logic         first;
    logic         last;
  } word_t;

  word_t cap_q[$];
  word_t exp_q[$];
  logic  m_dir;
  bit    rnd_ready;
  int    checks, errors;

  sand_row_stream #(.CELLS(CELLS)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_region  (in_region),
    .in_floor   (in_floor),
    .in_first   (in_first),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_region (out_region),
    .out_floor  (out_floor),
    .out_first  (out_first),
    .out_last   (out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output capture just before each rising edge, where the handshake is decided.
  always @(negedge clk) begin
    #4;
    if (!reset && out_valid && out_ready)
      cap_q.push_back({out_region, out_floor, out_first, out_last});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic word_t mk(input logic [W-1:0] r, input logic [W-1:0] f,
                               input logic fi, input logic la);
    word_t w;
    w.region = r;
    w.floor  = f;
    w.first  = fi;
    w.last   = la;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ready();
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_word(input word_t w);
    logic acc;
    @(negedge clk);
    in_region = w.region;
    in_floor  = w.floor;
    in_first  = w.first;
    in_last   = w.last;
    in_valid  = 1'b1;
    set_ready();
    for (int n = 0; n < 300; n++) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) return;
      @(negedge clk);
      set_ready();
    end
    check("push_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    set_ready();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cap_q.delete();
    exp_q.delete();
    m_dir = 1'b0;
  endtask

  task automatic drain();
    int n;
    word_t c, e;
    n = 0;
    while (cap_q.size() < exp_q.size() && n < 600) begin
      @(negedge clk);
      set_ready();
      n++;
    end
    repeat (4) begin
      @(negedge clk);
      set_ready();
    end
    check("drain_count", 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; cap_q.size() > 0 && exp_q.size() > 0; i++) begin
      c = cap_q.pop_front();
      e = exp_q.pop_front();
      check($sformatf("w%0d_region", i), 32'(c.region), 32'(e.region));
      check($sformatf("w%0d_floor", i),  32'(c.floor),  32'(e.floor));
      check($sformatf("w%0d_first", i),  32'(c.first),  32'(e.first));
      check($sformatf("w%0d_last", i),   32'(c.last),   32'(e.last));
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  // Reference: flatten the whole row and sweep it one cell at a time, left to right.
  task automatic model_row(input word_t row[$]);
    int L;
    logic [1:0] rr[], ff[];
    logic [1:0] l, r;
    logic [W-1:0] tr, tf;
    word_t w;
    L  = row.size() * CELLS;
    rr = new[L];
    ff = new[L];
    foreach (row[k]) begin
      tr = row[k].region;
      tf = row[k].floor;
      for (int j = 0; j < CELLS; j++) begin
        rr[k*CELLS+j] = tr[2*(CELLS-1-j) +: 2];
        ff[k*CELLS+j] = tf[2*(CELLS-1-j) +: 2];
      end
    end
    for (int j = 0; j < L; j++) begin
      l = (j == 0)     ? WALL : ff[j-1];
      r = (j == L - 1) ? WALL : ff[j+1];
      if (rr[j] == SAND_AM) begin
        rr[j] = SAND;
      end else if (rr[j] == SAND) begin
        if (ff[j] == AIR) begin
          ff[j] = SAND_AM;
          rr[j] = AIR;
        end else if (l == AIR && r == AIR) begin
          if (m_dir) ff[j+1] = SAND_AM;
          else       ff[j-1] = SAND_AM;
          m_dir = !m_dir;
          rr[j] = AIR;
        end else if (l == AIR) begin
          ff[j-1] = SAND_AM;
          rr[j]   = AIR;
        end else if (r == AIR) begin
          ff[j+1] = SAND_AM;
          rr[j]   = AIR;
        end
      end
    end
    foreach (row[k]) begin
      for (int j = 0; j < CELLS; j++) begin
        tr[2*(CELLS-1-j) +: 2] = rr[k*CELLS+j];
        tf[2*(CELLS-1-j) +: 2] = ff[k*CELLS+j];
      end
      w = mk(tr, tf, k == 0, k == row.size() - 1);
      exp_q.push_back(w);
    end
  endtask

  function automatic logic [1:0] rand_floor_cell();
    int v;
    v = $urandom_range(0, 5);
    if (v <= 2) return AIR;
    else if (v == 3) return SAND;
    else if (v == 4) return SAND_AM;
    return WALL;
  endfunction

  initial begin
    word_t row[$];
    word_t w;
    int nw;

    checks    = 0;
    errors    = 0;
    m_dir     = 1'b0;
    rnd_ready = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_region = '0;
    in_floor  = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    reset = 1'b0;

    // Straight fall
    push_word(mk(8'h40, 8'h00, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h00, 8'h80, 1'b1, 1'b1));
    idle();
    drain();

    // Tie alternation over two single-word rows
    push_word(mk(8'h10, 8'h33, 1'b1, 1'b1));
    push_word(mk(8'h10, 8'h33, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h00, 8'hB3, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h00, 8'h3B, 1'b1, 1'b1));
    idle();
    drain();

    // Cross-word left move patches the previous word's floor
    push_word(mk(8'h00, 8'hFC, 1'b1, 1'b0));
    push_word(mk(8'h40, 8'hFF, 1'b0, 1'b1));
    exp_q.push_back(mk(8'h00, 8'hFE, 1'b1, 1'b0));
    exp_q.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1));
    idle();
    drain();

    // Settle
    push_word(mk(8'h80, 8'hFF, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h40, 8'hFF, 1'b1, 1'b1));
    idle();
    drain();

    // Backpressure: three-word row with the sink stalled for 6 cycles
    out_ready = 1'b0;
    push_word(mk(8'h40, 8'h00, 1'b1, 1'b0));
    push_word(mk(8'h04, 8'h00, 1'b0, 1'b0));
    push_word(mk(8'h01, 8'h00, 1'b0, 1'b1));
    @(negedge clk);
    in_region = 8'h00;
    in_floor  = 8'h00;
    in_first  = 1'b1;
    in_last   = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd0);
      check($sformatf("bp_hold_%0d", k),
            32'({out_valid, out_region, out_floor, out_first, out_last}),
            32'({1'b1, 8'h00, 8'h80, 1'b1, 1'b0}));
      @(negedge clk);
    end
    out_ready = 1'b1;
    push_word(mk(8'h00, 8'h00, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h00, 8'h80, 1'b1, 1'b0));
    exp_q.push_back(mk(8'h00, 8'h08, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h00, 8'h02, 1'b0, 1'b1));
    exp_q.push_back(mk(8'h00, 8'h00, 1'b1, 1'b1));
    idle();
    drain();

    // Reset mid-row, then a fresh single-word row with dir back at 0
    push_word(mk(8'h40, 8'h00, 1'b1, 1'b0));
    push_word(mk(8'h04, 8'h00, 1'b0, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    reset = 1'b0;
    cap_q.delete();
    exp_q.delete();
    push_word(mk(8'h10, 8'h33, 1'b1, 1'b1));
    exp_q.push_back(mk(8'h00, 8'hB3, 1'b1, 1'b1));
    idle();
    drain();

    // Random rows, back to back, against the reference model with a jittery sink
    do_reset();
    rnd_ready = 1'b1;
    for (int batch = 0; batch < 4; batch++) begin
      for (int q = 0; q < 3; q++) begin
        row.delete();
        nw = $urandom_range(1, 4);
        for (int k = 0; k < nw; k++) begin
          w.region = W'($urandom);
          for (int j = 0; j < CELLS; j++) w.floor[2*j +: 2] = rand_floor_cell();
          w.first = (k == 0);
          w.last  = (k == nw - 1);
          row.push_back(w);
        end
        model_row(row);
        foreach (row[k]) push_word(row[k]);
      end
      idle();
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sand_row_stream.md
# sand_row_stream

Streaming successor to the fixed 16-cell sand update: applies one gravity step to a row pair (region row above, floor row below) delivered as a sequence of `CELLS`-wide words over valid/ready. It has a three-slot window, so sand can move diagonally across word boundaries. The tie-break direction is carried across words and rows. It sits between the frame-buffer row reader and the row writer in the simulation sweep.

## Interface
- `CELLS`, 16: cells per word; each cell is 2 bits; `CELLS` ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  input word accepted when high together with `in_valid`.
- `in_region`  in  2·CELLS  region-row cells.
- `in_floor`  in  2·CELLS  floor-row cells.
- `in_first`  in  1  word is leftmost in the row.
- `in_last`  in  1  word is rightmost in the row; `in_first` and `in_last` may both be high.
- `out_valid`  out  1  output word present.
- `out_ready`  in  1  output word consumed when high together with `out_valid`.
- `out_region`, `out_floor`  out  2·CELLS each  updated cells.
- `out_first`, `out_last`  out  1 each  flags passed through with the word.

## Operation
- **Cell encoding:** AIR=00, SAND=01, SAND_AM=10 (moved this step), WALL=11.
- **Cell order:** cell `CELLS-1` (MSBs) is the leftmost cell. Words arrive left to right.
- **Row edges:** cells beyond the row edges read as WALL.
- **Update semantics:** the result equals processing the whole row one cell at a time, left to right, using the already-updated floor.
  - region SAND_AM → SAND.
  - region SAND over a floor AIR → region AIR, floor SAND_AM.
  - otherwise, if exactly one of floor-left / floor-right is AIR → move the sand diagonally into it as SAND_AM; region becomes AIR.
  - if both are AIR (a tie) → take left when `dir`=0, right when `dir`=1; then toggle `dir`.
  - otherwise the cell is unchanged.
  - WALL and AIR region cells never change.
- **Slots:**
  - C: raw word awaiting its right neighbour.
  - P: processed word whose rightmost floor cell may still be written.
  - O: final word, drives the outputs.
- **Processing event**, on accepting word N while C is valid and not last, or when C is last:
  - process C. Left floor neighbour = P's rightmost floor cell, or WALL if C is first. Right floor neighbour = N's leftmost floor cell, or WALL if C is last.
  - a move down-left out of C patches P's rightmost floor cell; the patched P moves to O.
  - a move down-right out of C writes SAND_AM into N's leftmost floor cell as N is stored into C.
  - processed C moves to P.
  - the event requires O to be empty or being consumed this cycle.
- **Final word of a row:** P is final once its right neighbour is the row edge. It moves to O on the next free cycle, before the next row's first word is processed.
- **Handshake:**
  - `in_ready` = !C_valid || (!C_last && O free this cycle).
  - while `out_valid` is high and `out_ready` is low, O holds stable.
- **Reset:** `out_valid`=0 and `in_ready`=1. All slots are cleared, `dir`=0 and the LFSR is at its seed. A reset mid-row discards in-flight words; the next accepted word must carry `in_first`.

## Timing
- Single-word row, accepted at edge 0: processed at edge 1, P→O at edge 2, `out_valid` high after edge 2.
- Multi-word row: word k reaches O at the edge that processes word k+1. The last word reaches O one edge after its own processing.
- Steady state: one word per cycle with `out_ready` held high, except for one bubble per row at the row boundary.
- Nothing combinational passes from input to output; `in_ready` depends combinationally on `out_ready`.

## Configuration
- `SAND_LFSR_EN` defined:
  - an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seed 8'h01, steps once per processing event.
  - the starting tie direction for that word is `dir ^ lfsr[0]`.
- Undefined: pure alternation of `dir`, fully deterministic. No LFSR flops.

## Structure
- Package `sand_pkg`: cell type (2-bit enum AIR/SAND/SAND_AM/WALL) and the LFSR seed/taps constants.
- Sub-module `sand_word_step`: combinational update of one word, given left/right floor neighbours and the incoming `dir`. It returns the new word, the left-patch flag, the right-patch flag and the outgoing `dir`.

## Test plan
All tests use `CELLS`=4.
1. **Straight fall:** single word, first+last, region 8'h40, floor 8'h00 → region 8'h00, floor 8'h80.
2. **Tie alternation:** region 8'h10, floor 8'h33 (both diagonals AIR), sent twice.
   - without `SAND_LFSR_EN`: first word gives floor 8'hB3, second gives floor 8'h3B; region 8'h00 both times.
3. **Cross-word left move:** word0 region 8'h00 floor 8'hFC; word1 region 8'h40 floor 8'hFF → word0 floor 8'hFE, word1 region 8'h00 floor 8'hFF.
4. **Settle:** region 8'h80, floor 8'hFF → region 8'h40, floor 8'hFF.
5. **Backpressure:** three-word row with `out_ready` low for 6 cycles.
   - at most 3 words accepted, `in_ready` low while full.
   - O stable while stalled; all 3 words emitted in order with the correct first/last flags.
6. **Reset mid-row:** assert `reset` after accepting 2 of 3 words → `out_valid`=0 and `in_ready`=1 immediately; a fresh single-word row is then processed correctly with `dir`=0.
